// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit frame arbiter: FSM encoding,
// header field widths and a packed header view.
package eth_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    localparam int ETH_HDR_BYTES = 14;
    localparam int MAC_W         = 48;
    localparam int TYPE_W        = 16;

    typedef logic [1:0] arb_state_t;

    typedef struct packed {
        logic [MAC_W-1:0]  dest_mac;
        logic [MAC_W-1:0]  src_mac;
        logic [TYPE_W-1:0] eth_type;
    } eth_hdr_t;

endpackage

// File: rtl/eth_tx_rr_pick.sv
// Combinational round-robin pick: the first requester found searching upward
// from last_i+1, wrapping modulo S_COUNT.
module eth_tx_rr_pick
    import eth_pkg::*;
#(
    parameter int S_COUNT   = 4,
    parameter int IDX_WIDTH = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] last_i,
    output logic                 found_o,
    output logic [IDX_WIDTH-1:0] index_o
);

    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        cand    = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            cand = IDX_WIDTH'((int'(last_i) + k) % S_COUNT);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                index_o = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Round-robin frame arbiter: grants one source at a time and passes its header
// and then its payload through combinationally until the tlast beat is taken.
module eth_tx_frame_arb
    import eth_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int IDX_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [S_COUNT-1:0]               s_eth_hdr_valid,
    output logic [S_COUNT-1:0]               s_eth_hdr_ready,
    input  logic [S_COUNT*MAC_W-1:0]         s_eth_dest_mac,
    input  logic [S_COUNT*MAC_W-1:0]         s_eth_src_mac,
    input  logic [S_COUNT*TYPE_W-1:0]        s_eth_type,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_eth_payload_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_eth_payload_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_eth_payload_axis_tvalid,
    output logic [S_COUNT-1:0]               s_eth_payload_axis_tready,
    input  logic [S_COUNT-1:0]               s_eth_payload_axis_tlast,
    input  logic [S_COUNT-1:0]               s_eth_payload_axis_tuser,

    output logic                             m_eth_hdr_valid,
    input  logic                             m_eth_hdr_ready,
    output logic [MAC_W-1:0]                 m_eth_dest_mac,
    output logic [MAC_W-1:0]                 m_eth_src_mac,
    output logic [TYPE_W-1:0]                m_eth_type,
    output logic [DATA_WIDTH-1:0]            m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_eth_payload_axis_tkeep,
    output logic                             m_eth_payload_axis_tvalid,
    input  logic                             m_eth_payload_axis_tready,
    output logic                             m_eth_payload_axis_tlast,
    output logic                             m_eth_payload_axis_tuser,

    output logic                             grant_valid,
    output logic [IDX_WIDTH-1:0]             grant_index,
    output logic                             busy
);

    arb_state_t            state_q, state_d;
    logic [IDX_WIDTH-1:0]  grant_q, grant_d;
    logic [IDX_WIDTH-1:0]  last_q, last_d;
    logic                  pick_found;
    logic [IDX_WIDTH-1:0]  pick_index;
    logic [KEEP_WIDTH-1:0] keep_mux;

    eth_tx_rr_pick #(
        .S_COUNT  (S_COUNT),
        .IDX_WIDTH(IDX_WIDTH)
    ) u_pick (
        .req_i  (s_eth_hdr_valid),
        .last_i (last_q),
        .found_o(pick_found),
        .index_o(pick_index)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_HDR;
                    grant_d = pick_index;
                    last_d  = pick_index;
                end
            end
            ST_HDR: begin
                if (m_eth_hdr_valid && m_eth_hdr_ready) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready &&
                    m_eth_payload_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q starts at the top index so that source 0 wins the first grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_WIDTH'(S_COUNT - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Both directions are pure muxes on the granted slice; everything outside
    // the active phase is forced to zero so idle sources are never accepted.
    always_comb begin
        s_eth_hdr_ready           = '0;
        m_eth_hdr_valid           = 1'b0;
        m_eth_dest_mac            = '0;
        m_eth_src_mac             = '0;
        m_eth_type                = '0;
        s_eth_payload_axis_tready = '0;
        m_eth_payload_axis_tdata  = '0;
        keep_mux                  = '0;
        m_eth_payload_axis_tvalid = 1'b0;
        m_eth_payload_axis_tlast  = 1'b0;
        m_eth_payload_axis_tuser  = 1'b0;
        case (state_q)
            ST_HDR: begin
                m_eth_hdr_valid          = s_eth_hdr_valid[grant_q];
                s_eth_hdr_ready[grant_q] = m_eth_hdr_ready;
                m_eth_dest_mac = s_eth_dest_mac[int'(grant_q)*MAC_W +: MAC_W];
                m_eth_src_mac  = s_eth_src_mac[int'(grant_q)*MAC_W +: MAC_W];
                m_eth_type     = s_eth_type[int'(grant_q)*TYPE_W +: TYPE_W];
            end
            ST_PAYLOAD: begin
                s_eth_payload_axis_tready[grant_q] = m_eth_payload_axis_tready;
                m_eth_payload_axis_tdata  =
                    s_eth_payload_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                keep_mux = s_eth_payload_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
                m_eth_payload_axis_tvalid = s_eth_payload_axis_tvalid[grant_q];
                m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast[grant_q];
                m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser[grant_q];
            end
            default: ;
        endcase
    end

    assign m_eth_payload_axis_tkeep = (KEEP_ENABLE != 0) ? keep_mux : '1;
    assign grant_valid = (state_q != ST_IDLE);
    assign grant_index = grant_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Scoreboard bench for eth_tx_frame_arb: a cycle driver issues frames per
// source, a monitor predicts grants round-robin and checks every output cycle.
module tb_eth_tx_frame_arb;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KW = 1;

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] typ;
        logic [3:0]  len;
        logic [63:0] data;
        logic [7:0]  user;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [S-1:0]    hv, s_hdr_ready, tv, s_tready, tl, tu;
    logic [S*48-1:0] dmac, smac;
    logic [S*16-1:0] etyp;
    logic [S*DW-1:0] td;
    logic            m_hdr_valid, mh_rdy, mt_rdy;
    logic [47:0]     m_dest, m_src;
    logic [15:0]     m_type;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid, m_tlast, m_tuser;
    logic            grant_valid, busy;
    logic [1:0]      grant_index;

    eth_tx_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_eth_hdr_valid(hv), .s_eth_hdr_ready(s_hdr_ready),
        .s_eth_dest_mac(dmac), .s_eth_src_mac(smac), .s_eth_type(etyp),
        .s_eth_payload_axis_tdata(td), .s_eth_payload_axis_tkeep({S*KW{1'b1}}),
        .s_eth_payload_axis_tvalid(tv), .s_eth_payload_axis_tready(s_tready),
        .s_eth_payload_axis_tlast(tl), .s_eth_payload_axis_tuser(tu),
        .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(mh_rdy),
        .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
        .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
        .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(mt_rdy),
        .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_index(grant_index), .busy(busy)
    );

    frame_t pend[S][$];
    frame_t exp_q[S][$];
    int     glog[$];
    int     total = 0;
    int     bad = 0;
    int     rdy_mode = 0;
    bit     gap_en = 1'b0;

    int     dph[S];
    int     dbt[S];
    frame_t dcur[S];

    int     mph = 0;
    int     mg = 0;
    int     mlast = S - 1;
    int     mbeat = 0;
    bit     mfirst = 1'b0;
    frame_t mcur;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int rr_next(int last, logic [S-1:0] req);
        int c;
        for (int off = 1; off <= S; off++) begin
            c = (last + off) % S;
            if (req[c[1:0]]) return c;
        end
        return 0;
    endfunction

    function automatic bit drained();
        bit d;
        d = (mph == 0);
        for (int i = 0; i < S; i++)
            if (pend[i].size() != 0 || exp_q[i].size() != 0 || dph[i] != 0) d = 1'b0;
        return d;
    endfunction

    task automatic send(int s, logic [47:0] d, logic [47:0] sm, logic [15:0] t,
                        int len, logic [7:0] user);
        frame_t f;
        f.dest = d;
        f.src  = sm;
        f.typ  = t;
        f.len  = 4'(len);
        f.data = {$urandom, $urandom};
        f.user = user;
        pend[s].push_back(f);
    endtask

    task automatic wait_drain(string nm, int limit);
        int n = 0;
        while (n < limit && !drained()) begin
            @(negedge clk); #1;
            n++;
        end
        if (!drained()) begin
            total++;
            bad++;
            $display("FAIL %s: traffic not drained after %0d cycles", nm, limit);
        end
    endtask

    // Stimulus driver: updates source signals one time unit after each rising edge.
    initial begin
        logic [S-1:0] hh, pl;
        logic [3:0]   pat;
        int           cyc;
        pat = 4'b1001;
        cyc = 0;
        hv = '0; tv = '0; tl = '0; tu = '0; td = '0;
        dmac = '0; smac = '0; etyp = '0;
        mh_rdy = 1'b1; mt_rdy = 1'b1;
        for (int i = 0; i < S; i++) begin dph[i] = 0; dbt[i] = 0; end
        forever begin
            @(negedge clk);
            hh = hv & s_hdr_ready;
            pl = tv & s_tready;
            @(posedge clk); #1;
            cyc++;
            case (rdy_mode)
                1: begin mh_rdy = 1'($urandom_range(0, 1)); mt_rdy = 1'($urandom_range(0, 1)); end
                2: begin mh_rdy = 1'b1; mt_rdy = pat[cyc % 4]; end
                default: begin mh_rdy = 1'b1; mt_rdy = 1'b1; end
            endcase
            if (!rst_n) begin
                hv = '0; tv = '0; tl = '0; tu = '0;
                for (int i = 0; i < S; i++) dph[i] = 0;
                continue;
            end
            for (int i = 0; i < S; i++) begin
                if (dph[i] == 1 && hh[i]) begin
                    hv[i] = 1'b0; dph[i] = 2; dbt[i] = 0; tv[i] = 1'b0;
                end else if (dph[i] == 2 && pl[i]) begin
                    tv[i] = 1'b0;
                    dbt[i]++;
                    if (dbt[i] == int'(dcur[i].len)) dph[i] = 0;
                end
                if (dph[i] == 0 && pend[i].size() > 0) begin
                    dcur[i] = pend[i].pop_front();
                    dmac[i*48 +: 48] = dcur[i].dest;
                    smac[i*48 +: 48] = dcur[i].src;
                    etyp[i*16 +: 16] = dcur[i].typ;
                    hv[i] = 1'b1;
                    exp_q[i].push_back(dcur[i]);
                    dph[i] = 1;
                end
                if (dph[i] == 2 && !tv[i] && (!gap_en || $urandom_range(0, 1) == 1)) begin
                    td[i*DW +: DW] = dcur[i].data[dbt[i]*8 +: 8];
                    tl[i] = (dbt[i] == int'(dcur[i].len) - 1);
                    tu[i] = dcur[i].user[dbt[i]];
                    tv[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: reference arbitration model plus per-cycle output checks.
    initial begin
        logic [S-1:0] oh;
        int w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mph = 0; mlast = S - 1;
                for (int i = 0; i < S; i++) exp_q[i].delete();
                continue;
            end
            oh = '0;
            oh[mg[1:0]] = 1'b1;
            case (mph)
                0: begin
                    chk("idle_quiet", 128'({busy, grant_valid, m_hdr_valid, m_tvalid,
                                             s_hdr_ready, s_tready}), 128'(0));
                    chk("idle_data", 128'({m_dest, m_src, m_type, m_tdata, m_tlast, m_tuser}),
                        128'(0));
                    if (|hv) begin
                        w = rr_next(mlast, hv);
                        mg = w; mlast = w;
                        chk("exp_avail", 128'(exp_q[w].size() > 0), 128'(1));
                        if (exp_q[w].size() > 0) mcur = exp_q[w].pop_front();
                        mph = 1; mfirst = 1'b1;
                    end
                end
                1: begin
                    if (mfirst) begin glog.push_back(int'(grant_index)); mfirst = 1'b0; end
                    chk("grant", 128'({grant_valid, busy, grant_index}), 128'({2'b11, mg[1:0]}));
                    chk("hdr_valid", 128'(m_hdr_valid), 128'(hv[mg[1:0]]));
                    chk("hdr_fields", 128'({m_dest, m_src, m_type}),
                        128'({mcur.dest, mcur.src, mcur.typ}));
                    chk("hdr_readies", 128'({s_hdr_ready, s_tready}),
                        128'({(mh_rdy ? oh : 4'b0), 4'b0}));
                    if (m_hdr_valid && mh_rdy) begin mph = 2; mbeat = 0; end
                end
                default: begin
                    chk("pl_readies", 128'({s_hdr_ready, s_tready}),
                        128'({4'b0, (mt_rdy ? oh : 4'b0)}));
                    chk("pl_valid", 128'({grant_index, m_tvalid}), 128'({mg[1:0], tv[mg[1:0]]}));
                    if (m_tvalid && mt_rdy) begin
                        chk("beat", 128'({m_tdata, m_tkeep, m_tlast, m_tuser}),
                            128'({mcur.data[mbeat*8 +: 8], 1'b1,
                                  (mbeat == int'(mcur.len) - 1), mcur.user[mbeat[2:0]]}));
                        mbeat++;
                        if (mbeat == int'(mcur.len)) mph = 0;
                    end
                end
            endcase
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int base, n;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", 128'({m_hdr_valid, m_tvalid, s_hdr_ready, s_tready, grant_valid,
                                 busy, grant_index, m_dest, m_tdata}), 128'(0));
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Single frame from source 0.
        send(0, 48'h020000000001, 48'h02000000AA00, 16'h0800, 4, 8'h00);
        wait_drain("single_src0", 200);

        // Reset in the middle of beat 2 of a 5-beat frame.
        send(0, 48'h0A0B0C0D0E0F, 48'h111111111111, 16'h86DD, 5, 8'h00);
        n = 0;
        while (!(mph == 2 && mbeat == 1) && n < 200) begin @(negedge clk); #1; n++; end
        chk("reached_beat2", 128'(mbeat), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async", 128'({m_hdr_valid, m_tvalid, s_hdr_ready, s_tready, grant_valid,
                               busy, grant_index}), 128'(0));
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        base = glog.size();
        for (int s = S - 1; s >= 0; s--) send(s, 48'($urandom), 48'($urandom), 16'($urandom), 2, 8'h00);
        wait_drain("post_reset", 400);
        for (int k = 0; k < 4; k++) chk("post_reset_order", 128'(glog[base+k]), 128'(k));

        // Three simultaneous requesters, randomised backpressure.
        rdy_mode = 1; gap_en = 1'b1;
        base = glog.size();
        for (int s = 0; s < 3; s++) send(s, 48'($urandom), 48'($urandom), 16'($urandom), 3, 8'h00);
        wait_drain("three_way", 400);
        for (int k = 0; k < 3; k++) chk("three_way_order", 128'(glog[base+k]), 128'(k));

        // Source 1 keeps requesting while source 3 waits: strict alternation.
        base = glog.size();
        for (int k = 0; k < 4; k++) begin
            send(1, 48'($urandom), 48'($urandom), 16'($urandom), 2, 8'($urandom));
            send(3, 48'($urandom), 48'($urandom), 16'($urandom), 2, 8'($urandom));
        end
        wait_drain("alternate", 1000);
        for (int k = 0; k < 8; k++) chk("alternate_order", 128'(glog[base+k]), 128'((k % 2 == 0) ? 3 : 1));

        // Output tready pattern 1,0,0,1 during a source 2 frame.
        rdy_mode = 2; gap_en = 1'b0;
        send(2, 48'($urandom), 48'($urandom), 16'($urandom), 6, 8'h00);
        wait_drain("tready_toggle", 300);

        // Single-beat errored frame from source 3.
        rdy_mode = 0;
        send(3, 48'h0000DEADBEEF, 48'h00000000CAFE, 16'h88B5, 1, 8'h01);
        wait_drain("single_beat", 100);

        // Random traffic.
        rdy_mode = 1; gap_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send($urandom_range(0, S - 1), 48'($urandom), 48'($urandom), 16'($urandom),
                 $urandom_range(1, 8), 8'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            #1;
        end
        wait_drain("random", 8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
